// File: rtl/note_tone_gen.sv
// rtl/note_tone_gen.sv - single-voice note tone generator with loadable tempo/beat generator; optional status outputs under TONE_GEN_STATUS_EN
module note_tone_gen #(
  parameter int CNT_W         = 20,
  parameter int BEAT_W        = 28,
  parameter int DIV_SHIFT     = 0,
  parameter int TEMPO_DEFAULT = 50000000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic [3:0]        NOTE,
  input  logic [1:0]        OCTAVE,
  input  logic              TEMPO_LOAD,
  input  logic [BEAT_W-1:0] TEMPO_DIV,
  output logic              TONE,
  output logic              ACTIVE,
  output logic              BEAT_PULSE,
`ifdef TONE_GEN_STATUS_EN
  output logic              BEAT_LEVEL,
  output logic [3:0]        CUR_NOTE,
  output logic              NOTE_CHG
`else
  output logic              BEAT_LEVEL
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  tone_cnt;
  logic [CNT_W-1:0]  half_reg;
  logic [CNT_W-1:0]  h_base;
  logic [CNT_W-1:0]  h_oct;
  logic [CNT_W-1:0]  h_eff;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] tempo_reg;
  logic [BEAT_W-1:0] tempo_new;
  logic              rest_req;
  logic              tone_term;
  logic              beat_term;

  // Note table lookup (C4..C5 half-periods at 100 MHz), scaled by DIV_SHIFT
  always_comb begin
    case (NOTE)
      4'd1:    h_base = CNT_W'(191113 >> DIV_SHIFT);
      4'd2:    h_base = CNT_W'(180388 >> DIV_SHIFT);
      4'd3:    h_base = CNT_W'(170265 >> DIV_SHIFT);
      4'd4:    h_base = CNT_W'(160705 >> DIV_SHIFT);
      4'd5:    h_base = CNT_W'(151685 >> DIV_SHIFT);
      4'd6:    h_base = CNT_W'(143172 >> DIV_SHIFT);
      4'd7:    h_base = CNT_W'(135139 >> DIV_SHIFT);
      4'd8:    h_base = CNT_W'(127551 >> DIV_SHIFT);
      4'd9:    h_base = CNT_W'(120395 >> DIV_SHIFT);
      4'd10:   h_base = CNT_W'(113636 >> DIV_SHIFT);
      4'd11:   h_base = CNT_W'(107259 >> DIV_SHIFT);
      4'd12:   h_base = CNT_W'(101239 >> DIV_SHIFT);
      4'd13:   h_base = CNT_W'(95557 >> DIV_SHIFT);
      default: h_base = '0;
    endcase
  end

  // Octave shift then clamp so the half-period is never zero
  always_comb begin
    case (OCTAVE)
      2'd1:    h_oct = h_base >> 1;
      2'd2:    h_oct = h_base >> 2;
      2'd3:    h_oct = h_base << 1;
      default: h_oct = h_base;
    endcase
    h_eff = (h_oct == '0) ? CNT_W'(1) : h_oct;
  end

  // Request decode and terminal-count detection for both counters
  always_comb begin
    rest_req  = !EN || (NOTE == 4'd0) || (NOTE > 4'd13);
    tone_term = (tone_cnt == half_reg - CNT_W'(1));
    beat_term = (beat_cnt == tempo_reg - BEAT_W'(1));
    tempo_new = (TEMPO_DIV == '0) ? BEAT_W'(1) : TEMPO_DIV;
  end

  // Tone state machine: note changes and stops only land on half-period boundaries
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      TONE     <= 1'b0;
      ACTIVE   <= 1'b0;
      tone_cnt <= '0;
      half_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          TONE     <= 1'b0;
          ACTIVE   <= 1'b0;
          tone_cnt <= '0;
          if (!rest_req) begin
            half_reg <= h_eff;
            ACTIVE   <= 1'b1;
            state    <= ST_RUN;
          end
        end
        default: begin
          if (tone_term) begin
            tone_cnt <= '0;
            if (!rest_req) begin
              TONE     <= ~TONE;
              half_reg <= h_eff;
            end else begin
              TONE   <= 1'b0;
              ACTIVE <= 1'b0;
              state  <= ST_IDLE;
            end
          end else begin
            tone_cnt <= tone_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Free-running beat generator; a tempo load restarts the count and suppresses that cycle's beat
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      beat_cnt   <= '0;
      tempo_reg  <= BEAT_W'(TEMPO_DEFAULT);
      BEAT_PULSE <= 1'b0;
      BEAT_LEVEL <= 1'b0;
    end else if (TEMPO_LOAD) begin
      beat_cnt   <= '0;
      tempo_reg  <= tempo_new;
      BEAT_PULSE <= 1'b0;
    end else if (beat_term) begin
      beat_cnt   <= '0;
      BEAT_PULSE <= 1'b1;
      BEAT_LEVEL <= ~BEAT_LEVEL;
    end else begin
      beat_cnt   <= beat_cnt + BEAT_W'(1);
      BEAT_PULSE <= 1'b0;
    end
  end

`ifdef TONE_GEN_STATUS_EN
  // Track the sounding note alongside half-period loads and flag value changes
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CUR_NOTE <= 4'd0;
      NOTE_CHG <= 1'b0;
    end else begin
      NOTE_CHG <= 1'b0;
      if (state == ST_IDLE) begin
        if (!rest_req) begin
          CUR_NOTE <= NOTE;
          NOTE_CHG <= (NOTE != CUR_NOTE);
        end
      end else if (tone_term) begin
        if (!rest_req) begin
          CUR_NOTE <= NOTE;
          NOTE_CHG <= (NOTE != CUR_NOTE);
        end else begin
          CUR_NOTE <= 4'd0;
          NOTE_CHG <= (CUR_NOTE != 4'd0);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_note_tone_gen.sv
// tb/tb_note_tone_gen.sv - directed self-checking bench for note_tone_gen
`timescale 1ns/1ps
module tb_note_tone_gen;

  localparam int BEAT_W = 28;
  localparam int TDEF   = 20;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              EN;
  logic [3:0]        NOTE;
  logic [1:0]        OCTAVE;
  logic              TEMPO_LOAD;
  logic [BEAT_W-1:0] TEMPO_DIV;
  logic              TONE;
  logic              ACTIVE;
  logic              BEAT_PULSE;
  logic              BEAT_LEVEL;
`ifdef TONE_GEN_STATUS_EN
  logic [3:0]        CUR_NOTE;
  logic              NOTE_CHG;
`endif

  int total = 0;
  int bad   = 0;

  note_tone_gen #(
    .CNT_W(20), .BEAT_W(BEAT_W), .DIV_SHIFT(14), .TEMPO_DEFAULT(TDEF)
  ) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .NOTE(NOTE), .OCTAVE(OCTAVE),
    .TEMPO_LOAD(TEMPO_LOAD), .TEMPO_DIV(TEMPO_DIV),
    .TONE(TONE), .ACTIVE(ACTIVE), .BEAT_PULSE(BEAT_PULSE),
`ifdef TONE_GEN_STATUS_EN
    .BEAT_LEVEL(BEAT_LEVEL), .CUR_NOTE(CUR_NOTE), .NOTE_CHG(NOTE_CHG)
`else
    .BEAT_LEVEL(BEAT_LEVEL)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic pick(input int sel);
    case (sel)
      0:       return TONE;
      1:       return ACTIVE;
      default: return BEAT_PULSE;
    endcase
  endfunction

  // count falling-edge samples until the selected output reaches lvl; -1 on timeout
  task automatic wait_for(input int sel, input logic lvl, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      if (n < 0) begin
        @(negedge CLK);
        if (pick(sel) === lvl) n = i;
      end
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; EN = 1'b0; NOTE = 4'd0; OCTAVE = 2'd0;
    TEMPO_LOAD = 1'b0; TEMPO_DIV = '0;
    repeat (3) @(negedge CLK);
    total++;
    if ({TONE, ACTIVE, BEAT_PULSE, BEAT_LEVEL} !== 4'b0000) begin
      bad++; $display("FAIL reset_outputs got=%b want=0000", {TONE, ACTIVE, BEAT_PULSE, BEAT_LEVEL});
    end
    RESET = 1'b0;
    @(negedge CLK);
    total++;
    if ({TONE, ACTIVE} !== 2'b00) begin
      bad++; $display("FAIL idle_after_reset got=%b want=00", {TONE, ACTIVE});
    end
  endtask

  task automatic test_tone_base;
    int n;
    EN = 1'b1; NOTE = 4'd1; OCTAVE = 2'd0;
    @(negedge CLK);
    total++;
    if ({ACTIVE, TONE} !== 2'b10) begin
      bad++; $display("FAIL start_active got=%b want=10", {ACTIVE, TONE});
    end
    wait_for(0, 1'b1, n);
    total++; if (n !== 11) begin bad++; $display("FAIL base_first_rise got=%0d want=11", n); end
    wait_for(0, 1'b0, n);
    total++; if (n !== 11) begin bad++; $display("FAIL base_high got=%0d want=11", n); end
    wait_for(0, 1'b1, n);
    total++; if (n !== 11) begin bad++; $display("FAIL base_low got=%0d want=11", n); end
  endtask

  task automatic test_rest_high;
    int n;
    NOTE = 4'd0;
    wait_for(0, 1'b0, n);
    total++; if (n !== 11) begin bad++; $display("FAIL rest_high_fall got=%0d want=11", n); end
    total++;
    if (ACTIVE !== 1'b0) begin bad++; $display("FAIL rest_high_active got=%b want=0", ACTIVE); end
  endtask

  task automatic test_octave;
    int n;
    NOTE = 4'd1; OCTAVE = 2'd1;
    @(negedge CLK);
    total++; if (ACTIVE !== 1'b1) begin bad++; $display("FAIL oct_active got=%b want=1", ACTIVE); end
    wait_for(0, 1'b1, n);
    total++; if (n !== 5) begin bad++; $display("FAIL oct1_rise got=%0d want=5", n); end
    wait_for(0, 1'b0, n);
    total++; if (n !== 5) begin bad++; $display("FAIL oct1_high got=%0d want=5", n); end
    OCTAVE = 2'd3;
    wait_for(0, 1'b1, n);
    total++; if (n !== 5) begin bad++; $display("FAIL oct3_pending got=%0d want=5", n); end
    wait_for(0, 1'b0, n);
    total++; if (n !== 22) begin bad++; $display("FAIL oct3_high got=%0d want=22", n); end
    wait_for(0, 1'b1, n);
    total++; if (n !== 22) begin bad++; $display("FAIL oct3_low got=%0d want=22", n); end
  endtask

  task automatic test_note_change;
    int n;
    OCTAVE = 2'd0;
    wait_for(0, 1'b0, n);
    total++; if (n !== 22) begin bad++; $display("FAIL oct0_pending got=%0d want=22", n); end
    wait_for(0, 1'b1, n);
    total++; if (n !== 11) begin bad++; $display("FAIL oct0_low got=%0d want=11", n); end
    repeat (4) @(negedge CLK);
    NOTE = 4'd13;
    wait_for(0, 1'b0, n);
    total++; if (n !== 7) begin bad++; $display("FAIL chg_finish_half got=%0d want=7", n); end
    wait_for(0, 1'b1, n);
    total++; if (n !== 5) begin bad++; $display("FAIL c5_low got=%0d want=5", n); end
    wait_for(0, 1'b0, n);
    total++; if (n !== 5) begin bad++; $display("FAIL c5_high got=%0d want=5", n); end
  endtask

  task automatic test_rest_low;
    int n;
    logic seen;
    NOTE = 4'd0;
    n = -1; seen = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      if (n < 0) begin
        @(negedge CLK);
        if (TONE !== 1'b0) seen = 1'b1;
        if (ACTIVE === 1'b0) n = i;
      end
    end
    total++; if (n !== 5) begin bad++; $display("FAIL rest_low_stop got=%0d want=5", n); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rest_low_edge got=%b want=0", seen); end
    NOTE = 4'd14;
    repeat (3) @(negedge CLK);
    total++; if ({ACTIVE, TONE} !== 2'b00) begin bad++; $display("FAIL note14_rest got=%b want=00", {ACTIVE, TONE}); end
    EN = 1'b0; NOTE = 4'd5;
    repeat (3) @(negedge CLK);
    total++; if ({ACTIVE, TONE} !== 2'b00) begin bad++; $display("FAIL en0_rest got=%b want=00", {ACTIVE, TONE}); end
    NOTE = 4'd0;
  endtask

  task automatic test_beat;
    int n;
    logic lvl;
    TEMPO_LOAD = 1'b1; TEMPO_DIV = 28'd4;
    @(negedge CLK);
    TEMPO_LOAD = 1'b0;
    total++; if (BEAT_PULSE !== 1'b0) begin bad++; $display("FAIL load_no_pulse got=%b want=0", BEAT_PULSE); end
    lvl = BEAT_LEVEL;
    wait_for(2, 1'b1, n);
    total++; if (n !== 4) begin bad++; $display("FAIL tempo4_first got=%0d want=4", n); end
    total++; if (BEAT_LEVEL !== ~lvl) begin bad++; $display("FAIL tempo4_level got=%b want=%b", BEAT_LEVEL, ~lvl); end
    wait_for(2, 1'b1, n);
    total++; if (n !== 4) begin bad++; $display("FAIL tempo4_second got=%0d want=4", n); end
    repeat (3) @(negedge CLK);
    lvl = BEAT_LEVEL;
    TEMPO_LOAD = 1'b1; TEMPO_DIV = 28'd4;
    @(negedge CLK);
    TEMPO_LOAD = 1'b0;
    total++;
    if ({BEAT_PULSE, BEAT_LEVEL} !== {1'b0, lvl}) begin
      bad++; $display("FAIL load_at_terminal got=%b want=%b", {BEAT_PULSE, BEAT_LEVEL}, {1'b0, lvl});
    end
    wait_for(2, 1'b1, n);
    total++; if (n !== 4) begin bad++; $display("FAIL after_coincident got=%0d want=4", n); end
    TEMPO_LOAD = 1'b1; TEMPO_DIV = '0;
    @(negedge CLK);
    TEMPO_LOAD = 1'b0;
    total++; if (BEAT_PULSE !== 1'b0) begin bad++; $display("FAIL tempo0_load got=%b want=0", BEAT_PULSE); end
    for (int i = 0; i < 4; i++) begin
      lvl = BEAT_LEVEL;
      @(negedge CLK);
      total++;
      if ({BEAT_PULSE, BEAT_LEVEL} !== {1'b1, ~lvl}) begin
        bad++; $display("FAIL tempo1_cycle%0d got=%b want=%b", i, {BEAT_PULSE, BEAT_LEVEL}, {1'b1, ~lvl});
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    n = -1;
    for (int i = 0; i < 4; i++) begin
      if (n < 0) begin
        if (BEAT_LEVEL === 1'b1) n = i; else @(negedge CLK);
      end
    end
    TEMPO_LOAD = 1'b1; TEMPO_DIV = 28'd1000;
    @(negedge CLK);
    TEMPO_LOAD = 1'b0;
    EN = 1'b1; NOTE = 4'd1; OCTAVE = 2'd0;
    wait_for(0, 1'b1, n);
    total++;
    if ({TONE, BEAT_LEVEL} !== 2'b11) begin
      bad++; $display("FAIL pre_reset_state got=%b want=11", {TONE, BEAT_LEVEL});
    end
    #2 RESET = 1'b1;
    #1;
    total++;
    if ({TONE, ACTIVE, BEAT_PULSE, BEAT_LEVEL} !== 4'b0000) begin
      bad++; $display("FAIL async_reset got=%b want=0000", {TONE, ACTIVE, BEAT_PULSE, BEAT_LEVEL});
    end
    EN = 1'b0; NOTE = 4'd0;
    @(negedge CLK);
    RESET = 1'b0;
    wait_for(2, 1'b1, n);
    total++; if (n !== TDEF) begin bad++; $display("FAIL default_tempo got=%0d want=%0d", n, TDEF); end
    total++; if ({ACTIVE, TONE} !== 2'b00) begin bad++; $display("FAIL post_reset_idle got=%b want=00", {ACTIVE, TONE}); end
  endtask

  initial begin
    test_reset;
    test_tone_base;
    test_rest_high;
    test_octave;
    test_note_change;
    test_rest_low;
    test_beat;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Programmable single-voice tone generator plus tempo/beat generator for the FPGA piano.
- Replaces fixed per-note dividers with one runtime-selected half-period counter: 13 chromatic notes C4..C5, octave shift, and glitch-free note changes.
- Tempo is loadable at runtime.
- TONE drives the speaker pin; BEAT_PULSE/BEAT_LEVEL drive the sequencer and LEDs.

Parameters:
- CNT_W, 20, tone counter and half-period width in bits.
- BEAT_W, 28, tempo counter width in bits.
- DIV_SHIFT, 0, right-shift applied to every note-table entry; use 14 in simulation to shrink periods.
- TEMPO_DEFAULT, 50000000, reset value of the tempo register in CLK cycles per quarter beat (500 ms at 100 MHz).

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  asynchronous, active-high reset.
- EN  in  1  tone enable; 0 is treated as rest.
- NOTE  in  4  0 = rest; 1..13 = C4, C#4, D4, D#4, E4, F4, F#4, G4, G#4, A4, A#4, B4, C5; 14 and 15 = rest.
- OCTAVE  in  2  0 = base; 1 = up one (half >>1); 2 = up two (half >>2); 3 = down one (half <<1).
- TEMPO_LOAD  in  1  one-cycle strobe that loads TEMPO_DIV.
- TEMPO_DIV  in  BEAT_W  new quarter-beat period in cycles; 0 is treated as 1.
- TONE  out  1  square-wave tone output.
- ACTIVE  out  1  high while the state machine is in RUN.
- BEAT_PULSE  out  1  one-cycle pulse at each quarter beat.
- BEAT_LEVEL  out  1  toggles at each quarter beat.

Behaviour:
- Reset values (asynchronous, all registers): TONE=0, ACTIVE=0, BEAT_PULSE=0, BEAT_LEVEL=0, tone counter=0, beat counter=0, half-period register=0, tempo register=TEMPO_DEFAULT, state=IDLE.
- Note table, half-period counts at 100 MHz: 191113, 180388, 170265, 160705, 151685, 143172, 135139, 127551, 120395, 113636, 107259, 101239, 95557.
- Effective half-period H:
  - H = (table >> DIV_SHIFT), then the OCTAVE shift.
  - Result is clamped to a minimum of 1.
  - Computed combinationally from the current NOTE/OCTAVE.
- A request is "rest" when EN=0 or NOTE is 0, 14 or 15.
- IDLE state:
  - TONE=0, ACTIVE=0, counter held at 0.
  - On a non-rest request: load half-period register with H and go to RUN next cycle.
  - TONE stays 0 for the first half-period.
- RUN state:
  - ACTIVE=1; counter increments each cycle.
  - When counter == half-1: counter <= 0, and the request is sampled on that cycle:
    - Non-rest: TONE toggles; half-period register <= H. A note change therefore takes effect only at a half-period boundary, so there are no runt pulses.
    - Rest with TONE=1: TONE <= 0, go to IDLE.
    - Rest with TONE=0: go to IDLE, TONE stays 0.
  - Tone therefore always stops low.
  - Requests between boundaries are ignored; only the value on the terminal cycle matters.
- Beat generator (free-running, independent of the tone state):
  - Counter runs 0..tempo-1.
  - On the terminal cycle: BEAT_PULSE=1 for exactly that cycle, BEAT_LEVEL toggles, counter <= 0.
  - TEMPO_LOAD: tempo <= max(TEMPO_DIV,1) and counter <= 0; no pulse that cycle.
  - TEMPO_LOAD coincident with the terminal cycle: the load wins, no pulse, BEAT_LEVEL unchanged.
  - Tempo = 1: BEAT_PULSE is high every cycle and BEAT_LEVEL toggles every cycle.
- Reset asserted mid-operation immediately forces all reset values, including a TONE or BEAT_PULSE that is currently high.
- All outputs are registered.

Optional Feature:
- Macro: TONE_GEN_STATUS_EN.
- When defined, adds two outputs:
  - CUR_NOTE (4 bits): the note currently sounding. Updated on the cycle the half-period register loads; 0 in IDLE; reset 0.
  - NOTE_CHG (1 bit): one-cycle pulse when CUR_NOTE changes value; reset 0.
- When undefined, neither port nor its logic exists; remaining behaviour is identical.

Test Plan:
- DIV_SHIFT=14; EN=1, NOTE=1, OCTAVE=0 from IDLE -> ACTIVE rises after 1 cycle; H=11; TONE period 22 cycles with the first rising edge 11 cycles after ACTIVE.
- Same setup, OCTAVE=1 -> half-period 5 cycles; OCTAVE=3 -> half-period 22 cycles.
- Switch NOTE 1 to 13 mid-half-period -> the current 11-cycle half completes, then half-periods of 5 cycles (95557>>14); no shorter high or low phase appears.
- NOTE=0 while TONE=1 -> TONE falls at the next boundary and ACTIVE falls with it. NOTE=0 while TONE=0 -> ACTIVE falls at the boundary with no extra edge.
- TEMPO_LOAD with TEMPO_DIV=4 -> BEAT_PULSE every 4 cycles, the first 4 cycles after the load. Load coincident with terminal -> no pulse. TEMPO_DIV=0 -> pulse every cycle.
- Assert RESET while TONE=1 and BEAT_LEVEL=1 -> all outputs 0 asynchronously. After release, the beat counter restarts and the first pulse arrives TEMPO_DEFAULT cycles later.
